// File: rtl/vedic_pkg.sv
// Shared definitions for the iterative vedic multiplier: state encoding and digit widths.
package vedic_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Each digit is 2 bits, so the 2x2 cell produces a 4-bit partial product.
    localparam int DIGIT_W = 2;
    localparam int PP_W    = 4;

endpackage

// File: rtl/vedic_multiplier.sv
// 2x2 unsigned vedic (Urdhva Tiryagbhyam) multiplier cell, purely combinational.
module vedic_multiplier (
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic [3:0] P
);

    logic w_cross0;
    logic w_cross1;
    logic w_carry1;
    logic w_top;

    // Vertical and crosswise products; the crosswise sum may carry into bit 2.
    always_comb begin
        w_cross0 = A[1] & B[0];
        w_cross1 = A[0] & B[1];
        w_carry1 = w_cross0 & w_cross1;
        w_top    = A[1] & B[1];
        P[0]     = A[0] & B[0];
        P[1]     = w_cross0 ^ w_cross1;
        P[2]     = w_top ^ w_carry1;
        P[3]     = w_top & w_carry1;
    end

endmodule

// File: rtl/vedic_seq_multiplier.sv
// Iterative WIDTH x WIDTH unsigned multiplier built around a single 2x2 vedic cell.
// Operands are split into 2-bit digits; one digit pair is multiplied per cycle and
// the shifted partial product is added into a 2*WIDTH-bit accumulator.
module vedic_seq_multiplier
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);

    localparam int NDIG  = WIDTH / 2;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW    = 2 * WIDTH;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    r_p;

    logic [DIGIT_W-1:0] w_adig [NDIG];
    logic [DIGIT_W-1:0] w_bdig [NDIG];
    logic [DIGIT_W-1:0] w_a_digit;
    logic [DIGIT_W-1:0] w_b_digit;
    logic [PP_W-1:0]    w_pp;
    logic [IDX_W:0]     w_sum_idx;
    logic [IDX_W+1:0]   w_shift;
    logic [PW-1:0]      w_term;
    logic [PW-1:0]      w_acc_next;
    logic               w_last;
    logic               w_accept;
    logic               w_release;

    // Slice the latched operands into digit arrays so the index counters pick a digit.
    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digits
            assign w_adig[gi] = r_a[DIGIT_W*gi +: DIGIT_W];
            assign w_bdig[gi] = r_b[DIGIT_W*gi +: DIGIT_W];
        end
    endgenerate

    assign w_a_digit = w_adig[r_i];
    assign w_b_digit = w_bdig[r_j];

    vedic_multiplier u_cell (
        .A (w_a_digit),
        .B (w_b_digit),
        .P (w_pp)
    );

    // Partial product weight is 4^(i+j), i.e. a left shift by 2*(i+j) bits.
    always_comb begin
        w_sum_idx  = {1'b0, r_i} + {1'b0, r_j};
        w_shift    = {w_sum_idx, 1'b0};
        w_term     = PW'(w_pp) << w_shift;
        w_acc_next = r_acc + w_term;
        w_last     = (r_i == IDX_LAST) && (r_j == IDX_LAST);
        w_accept   = in_valid && (r_state == ST_IDLE);
        w_release  = out_ready && (r_state == ST_DONE);
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (w_release) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; in_ready is forced low during reset.
    always_comb begin
        in_ready  = (r_state == ST_IDLE) && !rst;
        out_valid = (r_state == ST_DONE);
        busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    end

    // Datapath: operand latch, digit counters, accumulator and held product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_acc <= '0;
            r_p   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a   <= A;
                        r_b   <= B;
                        r_i   <= '0;
                        r_j   <= '0;
                        r_acc <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    if (r_j == IDX_LAST) begin
                        r_j <= '0;
                        r_i <= r_i + IDX_W'(1);
                    end else begin
                        r_j <= r_j + IDX_W'(1);
                    end
                    // The product register only changes on completion, so P is
                    // stable for the whole DONE phase.
                    if (w_last) begin
                        r_p <= w_acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign P = r_p;

endmodule
